hazard_control: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sits beside the operand-forwarding logic and handles the hazards forwarding cannot resolve:
- load-use dependencies;
- CSR serialization;
- data-memory back-pressure;
- taken-branch redirects held across fetch back-pressure.

It drives per-register stall and flush controls and the fetch redirect. It also keeps saturating stall and redirect counters.

---
 rtl/hazard_control_pkg.sv | 48 ++++
 rtl/hazard_control_if.sv | 60 ++++++
 rtl/hazard_control_sat_counter.sv | 33 +++
 rtl/hazard_control.sv | 110 +++++++++++
 tb/tb_hazard_control.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_pkg.sv
// Shared types for the pipeline hazard controller: writeback source,
// CSR operation, controller state and the bundle of stall/flush controls.
package hazard_control_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } writebackType_;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } CSROp_;

    typedef enum logic {
        HZ_RUN           = 1'b0,
        HZ_REDIRECT_WAIT = 1'b1
    } hazardState_;

    // Stall/flush controls driven towards the pipeline registers.
    typedef struct packed {
        logic stall_fetch;
        logic stall_fetch_decode;
        logic stall_decode_execute;
        logic stall_execute_memory;
        logic flush_fetch_decode;
        logic flush_decode_execute;
        logic bubble_memory_writeback;
    } hazard_ctrl_t;

    // Freeze the whole front of the pipe and drain a bubble to writeback.
    localparam hazard_ctrl_t CTRL_MEM_STALL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    // Kill the two younger instructions behind a taken branch.
    localparam hazard_ctrl_t CTRL_REDIRECT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Hold fetch and decode, insert a bubble into execute.
    localparam hazard_ctrl_t CTRL_HOLD_DEC  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // True when a source operand is actually read and names the given register.
    function automatic logic reads_reg(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline-status inputs and hazard-control outputs of the hazard controller.
// slave: the hazard controller; master: the pipeline datapath.
interface hazard_control_if
    import hazard_control_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32
);
    logic                     fetchDecodeValid;
    logic [4:0]               fetchDecodeRegister1;
    logic [4:0]               fetchDecodeRegister2;
    logic                     fetchDecodeUses1;
    logic                     fetchDecodeUses2;
    CSROp_                    fetchDecodeCSROp;
    logic                     decodeExecuteValid;
    logic [4:0]               decodeExecuteDestinationRegister;
    writebackType_            decodeExecuteWritebackType;
    logic                     executeMemoryValid;
    logic                     executeBranchTaken;
    logic [31:0]              executeBranchTarget;
    logic                     memoryBusy;
    logic                     fetchReady;

    logic                     stallFetch;
    logic                     stallFetchDecode;
    logic                     stallDecodeExecute;
    logic                     stallExecuteMemory;
    logic                     flushFetchDecode;
    logic                     flushDecodeExecute;
    logic                     bubbleMemoryWriteback;
    logic                     redirectValid;
    logic [31:0]              redirectTarget;
    logic                     redirectPending;
    logic [COUNTER_WIDTH-1:0] stallCount;
    logic [COUNTER_WIDTH-1:0] redirectCount;

    modport slave (
        input  fetchDecodeValid, fetchDecodeRegister1, fetchDecodeRegister2,
               fetchDecodeUses1, fetchDecodeUses2, fetchDecodeCSROp,
               decodeExecuteValid, decodeExecuteDestinationRegister,
               decodeExecuteWritebackType, executeMemoryValid,
               executeBranchTaken, executeBranchTarget, memoryBusy, fetchReady,
        output stallFetch, stallFetchDecode, stallDecodeExecute, stallExecuteMemory,
               flushFetchDecode, flushDecodeExecute, bubbleMemoryWriteback,
               redirectValid, redirectTarget, redirectPending,
               stallCount, redirectCount
    );

    modport master (
        output fetchDecodeValid, fetchDecodeRegister1, fetchDecodeRegister2,
               fetchDecodeUses1, fetchDecodeUses2, fetchDecodeCSROp,
               decodeExecuteValid, decodeExecuteDestinationRegister,
               decodeExecuteWritebackType, executeMemoryValid,
               executeBranchTaken, executeBranchTarget, memoryBusy, fetchReady,
        input  stallFetch, stallFetchDecode, stallDecodeExecute, stallExecuteMemory,
               flushFetchDecode, flushDecodeExecute, bubbleMemoryWriteback,
               redirectValid, redirectTarget, redirectPending,
               stallCount, redirectCount
    );

endinterface

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: advance on enable unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use and CSR stalls, data-memory
// back-pressure and branch redirects held until fetch accepts them.
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    hazard_control_if.slave hz
);
    hazardState_  state_q, state_d;
    logic [31:0]  pending_target_q, pending_target_d;
    hazard_ctrl_t ctrl;
    logic         redirect_valid;
    logic [31:0]  redirect_target;
    logic         branch_taken;
    logic         load_use;
    logic         csr_drain;

    // Hazard conditions decoded from the pipeline registers.
    assign branch_taken = hz.executeBranchTaken && hz.decodeExecuteValid;
    assign load_use     = hz.decodeExecuteValid
                       && (hz.decodeExecuteWritebackType == WB_MEM)
                       && (hz.decodeExecuteDestinationRegister != 5'd0)
                       && hz.fetchDecodeValid
                       && (reads_reg(hz.fetchDecodeUses1, hz.fetchDecodeRegister1,
                                     hz.decodeExecuteDestinationRegister)
                        || reads_reg(hz.fetchDecodeUses2, hz.fetchDecodeRegister2,
                                     hz.decodeExecuteDestinationRegister));
    assign csr_drain    = hz.fetchDecodeValid && (hz.fetchDecodeCSROp != CSR_NONE)
                       && (hz.decodeExecuteValid || hz.executeMemoryValid);

    // Priority-ordered control outputs and FSM next state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        ctrl             = '0;
        redirect_valid   = 1'b0;
        redirect_target  = '0;
        state_d          = state_q;
        pending_target_d = pending_target_q;
        if (!reset) begin
            if (hz.memoryBusy) begin
                ctrl = CTRL_MEM_STALL;
                // A parked redirect keeps being offered while memory is busy.
                if (state_q == HZ_REDIRECT_WAIT) begin
                    redirect_valid  = 1'b1;
                    redirect_target = pending_target_q;
                    if (hz.fetchReady) begin
                        state_d = HZ_RUN;
                    end
                end
            end else if (branch_taken && (state_q == HZ_RUN)) begin
                ctrl            = CTRL_REDIRECT;
                redirect_valid  = 1'b1;
                redirect_target = hz.executeBranchTarget;
                if (!hz.fetchReady) begin
                    pending_target_d = hz.executeBranchTarget;
                    state_d          = HZ_REDIRECT_WAIT;
                end
            end else if (state_q == HZ_REDIRECT_WAIT) begin
                ctrl            = CTRL_REDIRECT;
                redirect_valid  = 1'b1;
                redirect_target = pending_target_q;
                if (hz.fetchReady) begin
                    state_d = HZ_RUN;
                end
            end else if (load_use || csr_drain) begin
                ctrl = CTRL_HOLD_DEC;
            end
        end
    end

    // FSM state and parked redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= HZ_RUN;
            pending_target_q <= '0;
        end else begin
            state_q          <= state_d;
            pending_target_q <= pending_target_d;
        end
    end

    assign hz.stallFetch            = ctrl.stall_fetch;
    assign hz.stallFetchDecode      = ctrl.stall_fetch_decode;
    assign hz.stallDecodeExecute    = ctrl.stall_decode_execute;
    assign hz.stallExecuteMemory    = ctrl.stall_execute_memory;
    assign hz.flushFetchDecode      = ctrl.flush_fetch_decode;
    assign hz.flushDecodeExecute    = ctrl.flush_decode_execute;
    assign hz.bubbleMemoryWriteback = ctrl.bubble_memory_writeback;
    assign hz.redirectValid         = redirect_valid;
    assign hz.redirectTarget        = redirect_target;
    assign hz.redirectPending       = (state_q == HZ_REDIRECT_WAIT);

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (ctrl.stall_fetch_decode),
        .count_o (hz.stallCount)
    );

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_redirect_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (redirect_valid && hz.fetchReady),
        .count_o (hz.redirectCount)
    );

endmodule

// File: tb/tb_hazard_control.sv
// Directed testbench for hazard_control: single-cycle vector table followed
// by multi-cycle sequences for redirects, drains, reset and saturation.
module tb_hazard_control;
    import hazard_control_pkg::*;

    localparam int unsigned CW = 4;

    // Control bit order: stallF, stallFD, stallDE, stallEM, flushFD, flushDE, bubbleMW.
    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_HOLD  = 7'b110_0010;
    localparam logic [6:0] C_FLUSH = 7'b000_0110;
    localparam logic [6:0] C_MEM   = 7'b111_1001;

    typedef struct packed {
        logic          fd_valid;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic          use1;
        logic          use2;
        CSROp_         csr;
        logic          de_valid;
        logic [4:0]    rd;
        writebackType_ wb;
        logic          em_valid;
        logic          br;
        logic [31:0]   tgt;
        logic          mb;
        logic          fr;
    } in_t;

    typedef struct packed {
        in_t         stim;
        logic [6:0]  exp_ctrl;
        logic        exp_rv;
        logic [31:0] exp_rt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   failures  = 0;
    vec_t vectors[$];

    always #5 clk = ~clk;

    hazard_control_if #(.COUNTER_WIDTH(CW)) hz ();

    hazard_control #(.COUNTER_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t idle_in();
        in_t t;
        t     = '0;
        t.csr = CSR_NONE;
        t.wb  = WB_ALU;
        t.fr  = 1'b1;
        return t;
    endfunction

    function automatic in_t load_use_in(input logic [4:0] rd);
        in_t t;
        t          = idle_in();
        t.fd_valid = 1'b1;
        t.rs1      = 5'd5;
        t.use1     = 1'b1;
        t.de_valid = 1'b1;
        t.rd       = rd;
        t.wb       = WB_MEM;
        return t;
    endfunction

    function automatic in_t branch_in(input logic fr);
        in_t t;
        t          = idle_in();
        t.de_valid = 1'b1;
        t.br       = 1'b1;
        t.tgt      = 32'h0000_0100;
        t.fr       = fr;
        return t;
    endfunction

    task automatic apply(input in_t t);
        hz.fetchDecodeValid                 = t.fd_valid;
        hz.fetchDecodeRegister1             = t.rs1;
        hz.fetchDecodeRegister2             = t.rs2;
        hz.fetchDecodeUses1                 = t.use1;
        hz.fetchDecodeUses2                 = t.use2;
        hz.fetchDecodeCSROp                 = t.csr;
        hz.decodeExecuteValid               = t.de_valid;
        hz.decodeExecuteDestinationRegister = t.rd;
        hz.decodeExecuteWritebackType       = t.wb;
        hz.executeMemoryValid               = t.em_valid;
        hz.executeBranchTaken               = t.br;
        hz.executeBranchTarget              = t.tgt;
        hz.memoryBusy                       = t.mb;
        hz.fetchReady                       = t.fr;
    endtask

    function automatic logic [6:0] act_ctrl();
        return {hz.stallFetch, hz.stallFetchDecode, hz.stallDecodeExecute,
                hz.stallExecuteMemory, hz.flushFetchDecode, hz.flushDecodeExecute,
                hz.bubbleMemoryWriteback};
    endfunction

    // Compare all combinational outputs at the falling edge.
    task automatic check_out(input string name, input logic [6:0] ec, input logic erv,
                             input logic [31:0] ert, input logic epend);
        @(negedge clk);
        check({name, ".ctrl"}, 64'(act_ctrl()), 64'(ec));
        check({name, ".rv"},   64'(hz.redirectValid), 64'(erv));
        check({name, ".rt"},   64'(hz.redirectTarget), 64'(ert));
        check({name, ".pend"}, 64'(hz.redirectPending), 64'(epend));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(idle_in());
        tick();
        reset = 1'b0;
    endtask

    task automatic add(input in_t t, input logic [6:0] ec, input logic erv, input logic [31:0] ert);
        vec_t v;
        v.stim     = t;
        v.exp_ctrl = ec;
        v.exp_rv   = erv;
        v.exp_rt   = ert;
        vectors.push_back(v);
    endtask

    initial begin
        in_t t;

        // Reset state: outputs forced low even with memory busy.
        reset = 1'b1;
        apply(idle_in());
        tick();
        t    = idle_in();
        t.mb = 1'b1;
        apply(t);
        check_out("reset", C_NONE, 1'b0, 32'h0, 1'b0);
        check("reset.stall_cnt",    64'(hz.stallCount), 64'd0);
        check("reset.redirect_cnt", 64'(hz.redirectCount), 64'd0);
        tick();
        do_reset();

        // Single-cycle vectors, all from RUN with fetch ready.
        add(idle_in(), C_NONE, 1'b0, 32'h0);
        add(load_use_in(5'd5), C_HOLD, 1'b0, 32'h0);
        add(load_use_in(5'd0), C_NONE, 1'b0, 32'h0);
        t = load_use_in(5'd5); t.use1 = 1'b0;                     add(t, C_NONE, 1'b0, 32'h0);
        t = load_use_in(5'd7); t.rs2 = 5'd7; t.use2 = 1'b1;      add(t, C_HOLD, 1'b0, 32'h0);
        t = load_use_in(5'd5); t.wb = WB_ALU;                     add(t, C_NONE, 1'b0, 32'h0);
        t = load_use_in(5'd5); t.fd_valid = 1'b0;                 add(t, C_NONE, 1'b0, 32'h0);
        add(branch_in(1'b1), C_FLUSH, 1'b1, 32'h0000_0100);
        t = branch_in(1'b1); t.de_valid = 1'b0;                   add(t, C_NONE, 1'b0, 32'h0);
        t = idle_in(); t.mb = 1'b1;                               add(t, C_MEM, 1'b0, 32'h0);
        t = branch_in(1'b1); t.mb = 1'b1;                         add(t, C_MEM, 1'b0, 32'h0);
        t = load_use_in(5'd5); t.br = 1'b1; t.tgt = 32'h0000_0240;
                                                                  add(t, C_FLUSH, 1'b1, 32'h0000_0240);
        t = idle_in(); t.fd_valid = 1'b1; t.csr = CSR_RW; t.de_valid = 1'b1;
                                                                  add(t, C_HOLD, 1'b0, 32'h0);
        t = idle_in(); t.fd_valid = 1'b1; t.csr = CSR_RS;         add(t, C_NONE, 1'b0, 32'h0);
        t = load_use_in(5'd5); t.mb = 1'b1;                       add(t, C_MEM, 1'b0, 32'h0);

        for (int i = 0; i < vectors.size(); i++) begin
            apply(vectors[i].stim);
            check_out($sformatf("vec%0d", i), vectors[i].exp_ctrl, vectors[i].exp_rv,
                      vectors[i].exp_rt, 1'b0);
            tick();
        end

        // Load-use lasts one cycle once the bubble reaches execute.
        do_reset();
        apply(load_use_in(5'd5));
        check_out("lu.c0", C_HOLD, 1'b0, 32'h0, 1'b0);
        tick();
        t = load_use_in(5'd5); t.de_valid = 1'b0;
        apply(t);
        check_out("lu.c1", C_NONE, 1'b0, 32'h0, 1'b0);
        check("lu.stall_cnt", 64'(hz.stallCount), 64'd1);
        tick();

        // Branch accepted immediately never parks.
        do_reset();
        apply(branch_in(1'b1));
        check_out("br_rdy.c0", C_FLUSH, 1'b1, 32'h0000_0100, 1'b0);
        tick();
        apply(idle_in());
        check_out("br_rdy.c1", C_NONE, 1'b0, 32'h0, 1'b0);
        check("br_rdy.redirect_cnt", 64'(hz.redirectCount), 64'd1);
        tick();

        // Branch refused for 3 cycles: redirect held 4 cycles.
        do_reset();
        apply(branch_in(1'b0));
        check_out("br_busy.c0", C_FLUSH, 1'b1, 32'h0000_0100, 1'b0);
        tick();
        t = idle_in(); t.fr = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            apply(t);
            check_out($sformatf("br_busy.c%0d", c), C_FLUSH, 1'b1, 32'h0000_0100, 1'b1);
            tick();
        end
        check("br_busy.redirect_cnt_mid", 64'(hz.redirectCount), 64'd0);
        apply(idle_in());
        check_out("br_busy.c3", C_FLUSH, 1'b1, 32'h0000_0100, 1'b1);
        tick();
        apply(idle_in());
        check_out("br_busy.c4", C_NONE, 1'b0, 32'h0, 1'b0);
        check("br_busy.redirect_cnt", 64'(hz.redirectCount), 64'd1);
        tick();

        // Memory busy freezes a branch; it fires once memory frees.
        do_reset();
        t = branch_in(1'b1); t.mb = 1'b1;
        for (int c = 0; c < 2; c++) begin
            apply(t);
            check_out($sformatf("mb_br.c%0d", c), C_MEM, 1'b0, 32'h0, 1'b0);
            tick();
        end
        apply(branch_in(1'b1));
        check_out("mb_br.c2", C_FLUSH, 1'b1, 32'h0000_0100, 1'b0);
        tick();

        // Parked redirect accepted during a memory stall.
        do_reset();
        apply(branch_in(1'b0));
        tick();
        t = idle_in(); t.mb = 1'b1;
        apply(t);
        check_out("wait_mb.c1", C_MEM, 1'b1, 32'h0000_0100, 1'b1);
        tick();
        apply(idle_in());
        check_out("wait_mb.c2", C_NONE, 1'b0, 32'h0, 1'b0);
        check("wait_mb.redirect_cnt", 64'(hz.redirectCount), 64'd1);
        check("wait_mb.stall_cnt",    64'(hz.stallCount), 64'd1);
        tick();

        // CSR op waits for execute and memory to drain.
        do_reset();
        t = idle_in(); t.fd_valid = 1'b1; t.csr = CSR_RW; t.de_valid = 1'b1; t.em_valid = 1'b1;
        apply(t);
        check_out("csr.c0", C_HOLD, 1'b0, 32'h0, 1'b0);
        tick();
        t.de_valid = 1'b0;
        apply(t);
        check_out("csr.c1", C_HOLD, 1'b0, 32'h0, 1'b0);
        tick();
        t.em_valid = 1'b0;
        apply(t);
        check_out("csr.c2", C_NONE, 1'b0, 32'h0, 1'b0);
        check("csr.stall_cnt", 64'(hz.stallCount), 64'd2);
        tick();

        // Reset while parked drops the redirect and clears counters.
        do_reset();
        apply(branch_in(1'b0));
        tick();
        t = idle_in(); t.mb = 1'b1; t.fr = 1'b0;
        apply(t);
        check_out("rst_wait.c1", C_MEM, 1'b1, 32'h0000_0100, 1'b1);
        tick();
        reset = 1'b1;
        t = idle_in(); t.fr = 1'b0;
        apply(t);
        tick();
        reset = 1'b0;
        check_out("rst_wait.c3", C_NONE, 1'b0, 32'h0, 1'b0);
        check("rst_wait.stall_cnt",    64'(hz.stallCount), 64'd0);
        check("rst_wait.redirect_cnt", 64'(hz.redirectCount), 64'd0);
        tick();

        // Stall counter saturates at 15 with a 4-bit counter.
        do_reset();
        apply(load_use_in(5'd5));
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        @(negedge clk);
        check("sat.stall_cnt", 64'(hz.stallCount), 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
